// File: rtl/biu_if.sv
// biu_if: external req/ack memory bus between the bus interface unit (master)
// and the memory/peripheral responder (slave).
interface biu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/biu.sv
// biu: single-transaction load/store bus interface unit with lane steering,
// load extension, misalignment and timeout faults. Optional LR/SC: BIU_LRSC_EN.
module biu #(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   opc_biu,
    input  logic         unsign,
    input  logic         lr,
    input  logic         sc,
    input  logic [31:0]  addr_csr,
    input  logic [31:0]  data_tobiu,
    output logic [31:0]  data_biu,
    output logic         rdy_biu,
    output logic         err_ma,
    output logic         err_acc,
    biu_if.master        mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [1:0]  off_reg, off_next;
    logic [1:0]  size_reg, size_next;
    logic        unsign_reg, unsign_next;
    logic        sc_reg, sc_next;
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [9:0]  cnt_reg, cnt_next;
    logic [31:0] data_reg, data_next;
    logic        rdy_reg, rdy_next;
    logic        ma_reg, ma_next;
    logic        acc_reg, acc_next;
`ifdef BIU_LRSC_EN
    logic        lr_reg, lr_next;
    logic        resv_v_reg, resv_v_next;
    logic [29:0] resv_a_reg, resv_a_next;
    logic        is_lr;
    assign is_lr = lr && (opc_biu == 3'b111);
`else
    logic        lr_unused;
    assign lr_unused = lr;
`endif

    // opc[1:0]: 00 no-op, 01 byte, 10 half, 11 word; opc[2] selects read
    logic [1:0]  op_size;
    logic        misaligned;
    logic        is_sc;
    logic [3:0]  be_calc;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign op_size    = opc_biu[1:0];
    assign is_sc      = sc && (opc_biu == 3'b011);
    assign misaligned = ((op_size == 2'b10) && addr_csr[0]) ||
                        ((op_size == 2'b11) && (addr_csr[1:0] != 2'b00));

    always_comb begin
        case (op_size)
            2'b01:   be_calc = 4'b0001 << addr_csr[1:0];
            2'b10:   be_calc = addr_csr[1] ? 4'b1100 : 4'b0011;
            default: be_calc = 4'b1111;
        endcase
    end

    // Each write lane takes the store byte that lands on it after replication
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_rep[8*gi +: 8] =
                (op_size == 2'b01) ? data_tobiu[7:0] :
                (op_size == 2'b10) ? data_tobiu[8*(gi%2) +: 8] :
                                     data_tobiu[8*gi +: 8];
        end
    endgenerate

    assign shifted = mem.bus_rdata >> {off_reg, 3'b000};

    always_comb begin
        case (size_reg)
            2'b01:   load_val = unsign_reg ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b10:   load_val = unsign_reg ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = mem.bus_rdata;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        req_next    = req_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        off_next    = off_reg;
        size_next   = size_reg;
        unsign_next = unsign_reg;
        sc_next     = sc_reg;
        be_next     = be_reg;
        wdata_next  = wdata_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;
        rdy_next    = 1'b0;
        ma_next     = 1'b0;
        acc_next    = 1'b0;
`ifdef BIU_LRSC_EN
        lr_next     = lr_reg;
        resv_v_next = resv_v_reg;
        resv_a_next = resv_a_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (op_size == 2'b00) begin
                        state_next = DONE;
                        rdy_next   = 1'b1;
                    end else if (misaligned) begin
                        state_next = DONE;
                        rdy_next   = 1'b1;
                        ma_next    = 1'b1;
                    end
`ifdef BIU_LRSC_EN
                    else if (is_sc && !(resv_v_reg && (resv_a_reg == addr_csr[31:2]))) begin
                        state_next = DONE;
                        rdy_next   = 1'b1;
                        data_next  = 32'd1;
                    end
`endif
                    else begin
                        state_next  = REQ;
                        req_next    = 1'b1;
                        we_next     = !opc_biu[2];
                        addr_next   = {addr_csr[31:2], 2'b00};
                        off_next    = addr_csr[1:0];
                        size_next   = op_size;
                        unsign_next = unsign;
                        sc_next     = is_sc;
                        be_next     = be_calc;
                        wdata_next  = wdata_rep;
                        cnt_next    = '0;
`ifdef BIU_LRSC_EN
                        lr_next     = is_lr;
`endif
                    end
`ifdef BIU_LRSC_EN
                    if (is_sc) begin
                        resv_v_next = 1'b0;
                    end
`endif
                end
            end
            REQ: begin
                if (mem.bus_err) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    rdy_next   = 1'b1;
                    acc_next   = 1'b1;
                end else if (mem.bus_ack) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    rdy_next   = 1'b1;
                    if (!we_reg) begin
                        data_next = load_val;
`ifdef BIU_LRSC_EN
                        if (lr_reg) begin
                            resv_v_next = 1'b1;
                            resv_a_next = addr_reg[31:2];
                        end
`endif
                    end else begin
                        if (sc_reg) begin
                            data_next = '0;
                        end
`ifdef BIU_LRSC_EN
                        if (resv_v_reg && (resv_a_reg == addr_reg[31:2])) begin
                            resv_v_next = 1'b0;
                        end
`endif
                    end
                end else if (cnt_reg == TO_LAST) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    rdy_next   = 1'b1;
                    acc_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 10'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            off_reg    <= '0;
            size_reg   <= '0;
            unsign_reg <= 1'b0;
            sc_reg     <= 1'b0;
            be_reg     <= '0;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            data_reg   <= RESET_RDATA;
            rdy_reg    <= 1'b0;
            ma_reg     <= 1'b0;
            acc_reg    <= 1'b0;
`ifdef BIU_LRSC_EN
            lr_reg     <= 1'b0;
            resv_v_reg <= 1'b0;
            resv_a_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            req_reg    <= req_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            off_reg    <= off_next;
            size_reg   <= size_next;
            unsign_reg <= unsign_next;
            sc_reg     <= sc_next;
            be_reg     <= be_next;
            wdata_reg  <= wdata_next;
            cnt_reg    <= cnt_next;
            data_reg   <= data_next;
            rdy_reg    <= rdy_next;
            ma_reg     <= ma_next;
            acc_reg    <= acc_next;
`ifdef BIU_LRSC_EN
            lr_reg     <= lr_next;
            resv_v_reg <= resv_v_next;
            resv_a_reg <= resv_a_next;
`endif
        end
    end

    assign mem.bus_req   = req_reg;
    assign mem.bus_we    = we_reg;
    assign mem.bus_addr  = addr_reg;
    assign mem.bus_be    = be_reg;
    assign mem.bus_wdata = wdata_reg;
    assign data_biu      = data_reg;
    assign rdy_biu       = rdy_reg;
    assign err_ma        = ma_reg;
    assign err_acc       = acc_reg;

endmodule

// File: tb/tb_biu.sv
// tb_biu: directed transactions against a transaction-level model of the
// bus interface unit; every cycle is compared on the falling clock edge.
`timescale 1ns/1ps
module tb_biu;

    localparam int          TO       = 4;
    localparam logic [31:0] RST_DATA = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opc_biu = 3'b000;
    logic        unsign = 1'b0;
    logic        lr = 1'b0;
    logic        sc = 1'b0;
    logic [31:0] addr_csr = '0;
    logic [31:0] data_tobiu = '0;
    logic [31:0] data_biu;
    logic        rdy_biu, err_ma, err_acc;

    biu_if bus_if ();

    biu #(.TIMEOUT(TO), .RESET_RDATA(RST_DATA)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opc_biu    (opc_biu),
        .unsign     (unsign),
        .lr         (lr),
        .sc         (sc),
        .addr_csr   (addr_csr),
        .data_tobiu (data_tobiu),
        .data_biu   (data_biu),
        .rdy_biu    (rdy_biu),
        .err_ma     (err_ma),
        .err_acc    (err_acc),
        .mem        (bus_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state and expected per-cycle outputs
    logic [31:0] m_data;
`ifdef BIU_LRSC_EN
    bit          m_resv_v;
    logic [29:0] m_resv_w;
`endif
    bit          exp_req, exp_rdy, exp_ma, exp_acc, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    logic [3:0]  cap_be;
    logic [31:0] cap_wdata, cap_addr;
    logic        cap_we;
    int          req_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                               input int sz, input bit uns);
        longint r, span, v;
        r    = longint'({32'h0, rd});
        span = 64'd1 << (8 * sz);
        v    = (r >> (8 * off)) % span;
        if (!uns && sz < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_req",  32'(bus_if.bus_req), 32'(exp_req));
            check("rdy_biu",  32'(rdy_biu),        32'(exp_rdy));
            check("err_ma",   32'(err_ma),         32'(exp_ma));
            check("err_acc",  32'(err_acc),        32'(exp_acc));
            check("data_biu", data_biu,            m_data);
            if (bus_if.bus_req) req_cycles++;
            if (exp_req) begin
                check("bus_addr", bus_if.bus_addr,   exp_addr);
                check("bus_we",   32'(bus_if.bus_we), 32'(exp_we));
                check("bus_be",   32'(bus_if.bus_be), 32'(exp_be));
                if (exp_we) check("bus_wdata", bus_if.bus_wdata, exp_wdata);
                cap_be    = bus_if.bus_be;
                cap_wdata = bus_if.bus_wdata;
                cap_addr  = bus_if.bus_addr;
                cap_we    = bus_if.bus_we;
            end
        end
    end

    // kind: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
    task automatic run(input string tag, input logic [2:0] opc, input bit uns, input bit l,
                       input bit s, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly, input int kind);
        int sz, off, n;
        bit is_sc, is_lr, mis, fail_sc, done;
        logic [31:0] wexp;
        logic [3:0]  bexp;
        sz    = (opc[1:0] == 2'd3) ? 4 : int'(opc[1:0]);
        off   = int'(addr[1:0]);
        is_sc = s && (opc == 3'b011);
        is_lr = l && (opc == 3'b111);
        mis   = (sz > 1) && ((off % sz) != 0);
`ifdef BIU_LRSC_EN
        fail_sc = is_sc && !mis && !(m_resv_v && (m_resv_w == addr[31:2]));
        if (is_sc) m_resv_v = 1'b0;
`else
        fail_sc = 1'b0;
        if (is_lr) fail_sc = 1'b0;
`endif
        bexp = '0;
        wexp = '0;
        for (int k = 0; k < 4; k++) begin
            if (sz != 0 && k >= off && k < off + sz) bexp[k] = 1'b1;
            if (sz != 0) wexp = wexp | (((wd >> (8 * (k % sz))) & 32'hFF) << (8 * k));
        end

        @(negedge clk);
        start = 1'b1; opc_biu = opc; unsign = uns; lr = l; sc = s;
        addr_csr = addr; data_tobiu = wd; bus_if.bus_rdata = rd;
        req_cycles = 0;
        @(posedge clk); #1;
        start = 1'b0; opc_biu = 3'b000; lr = 1'b0; sc = 1'b0;
        if (sz == 0 || mis || fail_sc) begin
            exp_rdy = 1'b1;
            exp_ma  = mis;
            if (fail_sc) m_data = 32'd1;
            @(posedge clk); #1;
            exp_rdy = 1'b0;
            exp_ma  = 1'b0;
        end else begin
            exp_req = 1'b1; exp_we = !opc[2];
            exp_addr = {addr[31:2], 2'b00}; exp_be = bexp; exp_wdata = wexp;
            n = 0;
            done = 1'b0;
            while (!done) begin
                if (n == dly && kind != 3) begin
                    bus_if.bus_ack = (kind == 0 || kind == 2);
                    bus_if.bus_err = (kind == 1 || kind == 2);
                end
                @(posedge clk); #1;
                bus_if.bus_ack = 1'b0;
                bus_if.bus_err = 1'b0;
                n++;
                if ((kind != 3 && n == dly + 1) || (kind == 3 && n == TO)) begin
                    done    = 1'b1;
                    exp_req = 1'b0;
                    exp_rdy = 1'b1;
                    if (kind == 0) begin
                        if (!opc[2]) begin
                            if (is_sc) m_data = '0;
`ifdef BIU_LRSC_EN
                            if (m_resv_v && m_resv_w == addr[31:2]) m_resv_v = 1'b0;
`endif
                        end else begin
                            m_data = model_load(rd, off, sz, uns);
`ifdef BIU_LRSC_EN
                            if (is_lr) begin
                                m_resv_v = 1'b1;
                                m_resv_w = addr[31:2];
                            end
`endif
                        end
                    end else begin
                        exp_acc = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
            exp_rdy = 1'b0;
            exp_acc = 1'b0;
        end
        $display("[TB] txn %s opc=%b addr=%h wdata=%h rdata=%h data_biu=%h req_cycles=%0d",
                 tag, opc, addr, wd, rd, data_biu, req_cycles);
    endtask

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = '0;
        m_data  = RST_DATA;
`ifdef BIU_LRSC_EN
        m_resv_v = 1'b0;
        m_resv_w = '0;
`endif
        exp_req = 1'b0; exp_rdy = 1'b0; exp_ma = 1'b0; exp_acc = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0;
        cap_be = '0; cap_wdata = '0; cap_addr = '0; cap_we = 1'b0; req_cycles = 0;
        rst = 1'b1;
        #2 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_data",  data_biu, 32'h1234_5678);
        check("reset_addr",  bus_if.bus_addr, 32'h0);
        check("reset_be",    32'(bus_if.bus_be), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run("r8_signed", 3'b101, 1'b0, 1'b0, 1'b0, 32'h1003, 32'h0, 32'h80FF_1234, 2, 0);
        check("tp_r8_data", data_biu, 32'hFFFF_FF80);
        check("tp_r8_be",   32'(cap_be), 32'h8);
        check("tp_r8_reqs", 32'(req_cycles), 32'd3);

        run("w16", 3'b010, 1'b0, 1'b0, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 0);
        check("tp_w16_be",    32'(cap_be), 32'hC);
        check("tp_w16_wdata", cap_wdata, 32'hABCD_ABCD);
        check("tp_w16_addr",  cap_addr, 32'h2000);
        check("tp_w16_we",    32'(cap_we), 32'd1);

        run("r32_misaligned", 3'b111, 1'b0, 1'b0, 1'b0, 32'h0006, 32'h0, 32'hDEAD_0000, 0, 0);
        check("tp_mis_data", data_biu, 32'hFFFF_FF80);
        check("tp_mis_reqs", 32'(req_cycles), 32'd0);

        run("r32_timeout", 3'b111, 1'b0, 1'b0, 1'b0, 32'h0008, 32'h0, 32'h5555_AAAA, 0, 3);
        check("tp_to_reqs", 32'(req_cycles), 32'd4);
        check("tp_to_data", data_biu, 32'hFFFF_FF80);

        run("r16_ack_err",  3'b110, 1'b1, 1'b0, 1'b0, 32'h000A, 32'h0, 32'h8001_7F00, 1, 2);
        run("r16_signed",   3'b110, 1'b0, 1'b0, 1'b0, 32'h000A, 32'h0, 32'h8001_7F00, 0, 0);
        check("tp_r16s_data", data_biu, 32'hFFFF_8001);
        run("r16_unsigned", 3'b110, 1'b1, 1'b0, 1'b0, 32'h000A, 32'h0, 32'h8001_7F00, 1, 0);
        check("tp_r16u_data", data_biu, 32'h0000_8001);
        run("r16_lo",       3'b110, 1'b0, 1'b0, 1'b0, 32'h0008, 32'h0, 32'h1234_9ABC, 0, 0);
        run("r8_unsigned",  3'b101, 1'b1, 1'b0, 1'b0, 32'h0011, 32'h0, 32'h1234_56F0, 1, 0);
        check("tp_r8u_data", data_biu, 32'h0000_0056);
        run("r8_u_hi",      3'b101, 1'b1, 1'b0, 1'b0, 32'h0012, 32'h0, 32'h12F4_0000, 0, 0);
        run("r32_unsign",   3'b111, 1'b0, 1'b0, 1'b0, 32'h0014, 32'h0, 32'h8765_4321, 2, 0);
        run("w8",           3'b001, 1'b0, 1'b0, 1'b0, 32'h0021, 32'h1234_565A, 32'h0, 0, 0);
        check("tp_w8_be",    32'(cap_be), 32'h2);
        check("tp_w8_wdata", cap_wdata, 32'h5A5A_5A5A);
        run("w32_err",      3'b011, 1'b0, 1'b0, 1'b0, 32'h0030, 32'hCAFE_F00D, 32'h0, 1, 1);
        run("w32",          3'b011, 1'b0, 1'b0, 1'b0, 32'h0034, 32'hCAFE_F00D, 32'h0, 3, 0);
        run("nop0",         3'b000, 1'b0, 1'b0, 1'b0, 32'h0040, 32'h0, 32'h0, 0, 0);
        run("nop4",         3'b100, 1'b0, 1'b0, 1'b0, 32'h0041, 32'h0, 32'h0, 0, 0);
        run("r16_mis",      3'b110, 1'b0, 1'b0, 1'b0, 32'h0001, 32'h0, 32'h0, 0, 0);
        run("w32_mis",      3'b011, 1'b0, 1'b0, 1'b0, 32'h0002, 32'h1, 32'h0, 0, 0);

        // Reset in the middle of a bus cycle, then a stray ack after release
        @(negedge clk);
        start = 1'b1; opc_biu = 3'b111; unsign = 1'b0; addr_csr = 32'h0040;
        @(posedge clk); #1;
        start = 1'b0; opc_biu = 3'b000;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0040; exp_be = 4'hF;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        exp_req = 1'b0;
        m_data  = RST_DATA;
`ifdef BIU_LRSC_EN
        m_resv_v = 1'b0;
`endif
        #1;
        check("rst_async_req",  32'(bus_if.bus_req), 32'd0);
        check("rst_async_data", data_biu, 32'h1234_5678);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        @(posedge clk); #1;
        $display("[TB] txn reset_mid_cycle data_biu=%h", data_biu);

        run("r32_after_rst", 3'b111, 1'b0, 1'b0, 1'b0, 32'h0044, 32'h0, 32'h1122_3344, 0, 0);
        check("tp_after_rst_data", data_biu, 32'h1122_3344);

        run("lr",  3'b111, 1'b0, 1'b1, 1'b0, 32'h0100, 32'h0, 32'hAAAA_5555, 1, 0);
        check("tp_lr_data", data_biu, 32'hAAAA_5555);
        run("sc1", 3'b011, 1'b0, 1'b0, 1'b1, 32'h0100, 32'h0000_0077, 32'h0, 0, 0);
        check("tp_sc1_data", data_biu, 32'h0);
        check("tp_sc1_reqs", 32'(req_cycles), 32'd1);
        check("tp_sc1_we",   32'(cap_we), 32'd1);
        run("sc2", 3'b011, 1'b0, 1'b0, 1'b1, 32'h0100, 32'h0000_0088, 32'h0, 0, 0);
`ifdef BIU_LRSC_EN
        check("tp_sc2_data", data_biu, 32'h1);
        check("tp_sc2_reqs", 32'(req_cycles), 32'd0);
`else
        check("tp_sc2_data", data_biu, 32'h0);
        check("tp_sc2_reqs", 32'(req_cycles), 32'd1);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
